// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory access unit: load/store op codes
// (same encoding as the control unit's alu_fnc), FSM states and size decode.
package mips_mem_pkg;

  localparam logic [4:0] FncLw  = 5'b01000;
  localparam logic [4:0] FncLhu = 5'b01001;
  localparam logic [4:0] FncLb  = 5'b01010;
  localparam logic [4:0] FncLh  = 5'b01011;
  localparam logic [4:0] FncLbu = 5'b01100;
  localparam logic [4:0] FncSw  = 5'b01101;
  localparam logic [4:0] FncSh  = 5'b01110;
  localparam logic [4:0] FncSb  = 5'b01111;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  typedef enum logic [1:0] {SizeNone, SizeByte, SizeHalf, SizeWord} size_e;

  // Access width of an op code; SizeNone marks an unknown code.
  function automatic size_e size_decode(input logic [4:0] fnc);
    size_e sz;
    case (fnc)
      FncLb, FncLbu, FncSb: sz = SizeByte;
      FncLh, FncLhu, FncSh: sz = SizeHalf;
      FncLw, FncSw:         sz = SizeWord;
      default:              sz = SizeNone;
    endcase
    return sz;
  endfunction

  function automatic logic fnc_is_load(input logic [4:0] fnc);
    return (fnc == FncLw) || (fnc == FncLhu) || (fnc == FncLb) ||
           (fnc == FncLh) || (fnc == FncLbu);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte/half lane steering for the data RAM: extracts and
// sign/zero-extends load data, and merges store data into a read word.
module mem_lane_align
  import mips_mem_pkg::*;
#(
  parameter bit BIG_END = 1'b1
) (
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [4:0]  fnc_i,
  input  size_e       size_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [1:0]  bsel;
  logic        hsel;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane positions counted from bit 0; big-endian puts byte 0 in the top lane.
  always_comb begin
    bsel   = BIG_END ? ~addr_lo_i : addr_lo_i;
    hsel   = BIG_END ? ~addr_lo_i[1] : addr_lo_i[1];
    byte_v = rdata_i[{bsel, 3'b000} +: 8];
    half_v = rdata_i[{hsel, 4'b0000} +: 16];
  end

  // Load extraction with sign or zero extension.
  always_comb begin
    ld_data_o = '0;
    case (fnc_i)
      FncLw:   ld_data_o = rdata_i;
      FncLb:   ld_data_o = {{24{byte_v[7]}}, byte_v};
      FncLbu:  ld_data_o = {24'b0, byte_v};
      FncLh:   ld_data_o = {{16{half_v[15]}}, half_v};
      FncLhu:  ld_data_o = {16'b0, half_v};
      default: ld_data_o = '0;
    endcase
  end

  // Store merge: replace only the addressed lane of the read word.
  always_comb begin
    st_word_o = rdata_i;
    case (size_i)
      SizeByte: st_word_o[{bsel, 3'b000} +: 8]   = wdata_i[7:0];
      SizeHalf: st_word_o[{hsel, 4'b0000} +: 16] = wdata_i[15:0];
      SizeWord: st_word_o = wdata_i;
      default:  st_word_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: executes loads and stores on a word-wide RAM
// without byte enables; sub-word stores are read-modify-write.
// Optional MEM_ALIGN_TRAP_EN: adds misalign_err and rejects misaligned
// word/half accesses instead of forcing them to alignment.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter bit          BIG_END = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [4:0]        req_fnc,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
`ifdef MEM_ALIGN_TRAP_EN
  output logic              misalign_err,
`endif
  input  logic              ram_ack
);

  state_e            state_q, state_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [4:0]        fnc_q, fnc_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;

  size_e       req_size;
  logic        req_ok;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  // Address bits above the RAM range are dropped so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];

`ifdef MEM_ALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic req_mis;
`endif

  mem_lane_align #(
    .BIG_END (BIG_END)
  ) u_lane (
    .rdata_i   (ram_rdata),
    .wdata_i   (wdata_q_unused_guard()),
    .addr_lo_i (addr_lo_q),
    .fnc_i     (fnc_q),
    .size_i    (size_decode(fnc_q)),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  // Store data lives in ram_wdata_q from accept until the merge in RD.
  function automatic logic [31:0] wdata_q_unused_guard();
    return ram_wdata_q;
  endfunction

  // Request decode: known op code with a matching load/store direction.
  always_comb begin
    req_size = size_decode(req_fnc);
    req_ok   = (req_size != SizeNone) && (req_rw == fnc_is_load(req_fnc));
`ifdef MEM_ALIGN_TRAP_EN
    req_mis  = ((req_size == SizeWord) && (req_addr[1:0] != 2'b00)) ||
               ((req_size == SizeHalf) && req_addr[0]);
`endif
  end

  // Next-state and registered RAM/response controls.
  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    fnc_d       = fnc_q;
    rsp_rdata_d = rsp_rdata_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
`ifdef MEM_ALIGN_TRAP_EN
    misalign_d  = misalign_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_lo_d   = req_addr[1:0];
          fnc_d       = req_fnc;
          rsp_rdata_d = '0;
          ram_wdata_d = req_wdata;
`ifdef MEM_ALIGN_TRAP_EN
          misalign_d  = 1'b0;
`endif
          if (!req_ok) begin
            state_d = DONE;
`ifdef MEM_ALIGN_TRAP_EN
          end else if (req_mis) begin
            state_d    = DONE;
            misalign_d = 1'b1;
`endif
          end else begin
            ram_en_d   = 1'b1;
            ram_addr_d = req_addr[ADDR_W+1:2];
            // SW needs no read; sub-word stores read first to merge.
            if (req_fnc == FncSw) begin
              ram_we_d = 1'b1;
              state_d  = WR;
            end else begin
              ram_we_d = 1'b0;
              state_d  = RD;
            end
          end
        end
      end
      RD: begin
        if (ram_ack) begin
          if (fnc_is_load(fnc_q)) begin
            rsp_rdata_d = ld_data;
            ram_en_d    = 1'b0;
            state_d     = DONE;
          end else begin
            ram_wdata_d = st_word;
            ram_we_d    = 1'b1;
            state_d     = WR;
          end
        end
      end
      WR: begin
        if (ram_ack) begin
          ram_en_d = 1'b0;
          ram_we_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; reset aborts any op.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_lo_q   <= '0;
      fnc_q       <= '0;
      rsp_rdata_q <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_lo_q   <= addr_lo_d;
      fnc_q       <= fnc_d;
      rsp_rdata_q <= rsp_rdata_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

`ifdef MEM_ALIGN_TRAP_EN
  // Misalignment flag, reported alongside rsp_valid.
  always_ff @(posedge clk) begin
    if (!reset) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
  assign misalign_err = misalign_q;
`endif

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_rdata = rsp_rdata_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (default parameters, BIG_END=1).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_rw;
  logic [4:0]  req_fnc;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        ram_en, ram_we, ram_ack;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
`ifdef MEM_ALIGN_TRAP_EN
  logic        misalign_err;
`endif

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_W  (10),
    .BIG_END (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rw       (req_rw),
    .req_fnc      (req_fnc),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
`ifdef MEM_ALIGN_TRAP_EN
    .misalign_err (misalign_err),
`endif
    .ram_ack      (ram_ack)
  );

  logic [31:0] ram_mem [1024];
  logic [31:0] mem_ref [1024];
  int dly_rd = 1;
  int dly_wr = 1;
  int n_chk  = 0;
  int n_err  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // 0 unknown, 1 load, 2 SW, 3 sub-word store
  function automatic int kind_of(input logic [4:0] f);
    case (f)
      5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100: return 1;
      5'b01101: return 2;
      5'b01110, 5'b01111: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int size_of(input logic [4:0] f);
    case (f)
      5'b01010, 5'b01100, 5'b01111: return 1;
      5'b01011, 5'b01001, 5'b01110: return 2;
      5'b01000, 5'b01101: return 4;
      default: return 0;
    endcase
  endfunction

  // Big-endian reference: byte i of a word sits 8*(3-i) bits up.
  function automatic logic [31:0] ref_load(input logic [4:0] f, input logic [31:0] a);
    logic [31:0] w, b, h;
    w = mem_ref[a[11:2]];
    b = (w >> (8 * (3 - int'(a[1:0])))) & 32'hff;
    h = (w >> (16 * (1 - int'(a[1])))) & 32'hffff;
    case (f)
      5'b01000: return w;
      5'b01100: return b;
      5'b01001: return h;
      5'b01010: return (b >= 128) ? (b | 32'hffff_ff00) : b;
      5'b01011: return (h >= 32768) ? (h | 32'hffff_0000) : h;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic ref_store(input logic [4:0] f, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w, mask;
    int sh;
    w = mem_ref[a[11:2]];
    if (size_of(f) == 4) begin
      w = wd;
    end else if (size_of(f) == 2) begin
      sh   = 16 * (1 - int'(a[1]));
      mask = 32'hffff << sh;
      w    = (w & ~mask) | ((wd & 32'hffff) << sh);
    end else begin
      sh   = 8 * (3 - int'(a[1:0]));
      mask = 32'hff << sh;
      w    = (w & ~mask) | ((wd & 32'hff) << sh);
    end
    mem_ref[a[11:2]] = w;
  endtask

  // RAM responder: acks in the dly-th cycle of each strobe.
  initial begin
    int cnt;
    cnt = 0;
    ram_ack = 1'b0;
    ram_rdata = '0;
    forever begin
      @(negedge clk);
      if (ram_en && reset) begin
        cnt++;
        if (cnt >= (ram_we ? dly_wr : dly_rd)) begin
          ram_ack = 1'b1;
          ram_rdata = ram_mem[ram_addr];
          if (ram_we) ram_mem[ram_addr] = ram_wdata;
          cnt = 0;
        end else begin
          ram_ack = 1'b0;
        end
      end else begin
        ram_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  task automatic run_op(input string nm, input logic rw, input logic [4:0] f,
                        input logic [31:0] a, input logic [31:0] wd, input int drd,
                        input int dwr, input logic [31:0] exp_rdata);
    int k, sz, lat, en, we, c, en_c, we_c;
    bit ok, mis, trap, addr_bad, ready_bad, got;
    logic [31:0] got_rdata;
    logic got_mis;
    k    = kind_of(f);
    sz   = size_of(f);
    ok   = (k != 0) && (rw == (k == 1));
    mis  = ok && (((sz == 4) && (a[1:0] != 2'b00)) || ((sz == 2) && a[0]));
    trap = 1'b0;
`ifdef MEM_ALIGN_TRAP_EN
    trap = mis;
`endif
    if (!ok || trap) begin lat = 1; en = 0; we = 0; end
    else if (k == 1) begin lat = drd + 1; en = drd; we = 0; end
    else if (k == 2) begin lat = dwr + 1; en = dwr; we = dwr; end
    else begin lat = drd + dwr + 1; en = drd + dwr; we = dwr; end
    dly_rd = drd;
    dly_wr = dwr;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    req_valid = 1'b1; req_rw = rw; req_fnc = f; req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    c = 1; en_c = 0; we_c = 0; addr_bad = 0; ready_bad = 0; got = 0;
    got_rdata = 'x; got_mis = 1'bx;
    while (c <= 60) begin
      if (ram_en) begin
        en_c++;
        if (ram_we) we_c++;
        if (ram_addr !== a[11:2]) addr_bad = 1;
      end
      if (req_ready) ready_bad = 1;
      if (rsp_valid) begin
        got = 1;
        got_rdata = rsp_rdata;
`ifdef MEM_ALIGN_TRAP_EN
        got_mis = misalign_err;
`endif
        break;
      end
      @(negedge clk);
      c++;
    end
    chk($sformatf("%s rsp_seen", nm), 32'(got), 32'd1);
    chk($sformatf("%s rdata", nm), got_rdata, exp_rdata);
    chk($sformatf("%s latency", nm), c, lat);
    chk($sformatf("%s ram_en_cycles", nm), en_c, en);
    chk($sformatf("%s ram_we_cycles", nm), we_c, we);
    chk($sformatf("%s ram_addr", nm), 32'(addr_bad), 32'd0);
    chk($sformatf("%s ready_low", nm), 32'(ready_bad), 32'd0);
`ifdef MEM_ALIGN_TRAP_EN
    chk($sformatf("%s misalign_err", nm), 32'(got_mis), 32'(trap));
`endif
    @(negedge clk);
    chk($sformatf("%s rsp_one_cycle", nm), 32'(rsp_valid), 32'd0);
    if (ok && !trap && (k >= 2)) ref_store(f, a, wd);
  endtask

  typedef struct {
    string       name;
    logic        rw;
    logic [4:0]  fnc;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          drd;
    int          dwr;
    logic        pre_en;
    logic [31:0] pre_val;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input string n, input logic rw, input logic [4:0] f,
                              input logic [31:0] a, input logic [31:0] wd, input int drd,
                              input int dwr, input logic pe, input logic [31:0] pv,
                              input logic [31:0] e);
    vec_t v;
    v.name = n; v.rw = rw; v.fnc = f; v.addr = a; v.wdata = wd; v.drd = drd;
    v.dwr = dwr; v.pre_en = pe; v.pre_val = pv; v.exp = e;
    return v;
  endfunction

  vec_t vec [18];
  logic [4:0] codes [8];

  initial begin
    logic [4:0]  f;
    logic [31:0] a, e;
    int sz;
    bit seen;

    for (int i = 0; i < 1024; i++) begin ram_mem[i] = '0; mem_ref[i] = '0; end
    vec[0]  = mk("sw_deadbeef", 0, 5'b01101, 32'h10, 32'hDEADBEEF, 1, 1, 0, 0, 32'h0);
    vec[1]  = mk("lw_back",     1, 5'b01000, 32'h10, 32'h0, 1, 1, 0, 0, 32'hDEADBEEF);
    vec[2]  = mk("lb_13",       1, 5'b01010, 32'h13, 32'h0, 2, 1, 1, 32'h11223344, 32'h44);
    vec[3]  = mk("lh_10",       1, 5'b01011, 32'h10, 32'h0, 1, 1, 0, 0, 32'h1122);
    vec[4]  = mk("lb_neg",      1, 5'b01010, 32'h10, 32'h0, 1, 1, 1, 32'h80FF7F01,
                 32'hFFFFFF80);
    vec[5]  = mk("lbu_10",      1, 5'b01100, 32'h10, 32'h0, 2, 1, 0, 0, 32'h80);
    vec[6]  = mk("lhu_12",      1, 5'b01001, 32'h12, 32'h0, 1, 1, 0, 0, 32'h7F01);
    vec[7]  = mk("lh_neg",      1, 5'b01011, 32'h10, 32'h0, 3, 1, 0, 0, 32'hFFFF80FF);
    vec[8]  = mk("sb_11",       0, 5'b01111, 32'h11, 32'hAB, 3, 3, 1, 32'h11223344, 32'h0);
    vec[9]  = mk("lw_after_sb", 1, 5'b01000, 32'h10, 32'h0, 1, 1, 0, 0, 32'h11AB3344);
    vec[10] = mk("sh_12",       0, 5'b01110, 32'h12, 32'h1234CAFE, 2, 1, 0, 0, 32'h0);
    vec[11] = mk("lw_after_sh", 1, 5'b01000, 32'h10, 32'h0, 1, 2, 0, 0, 32'h11ABCAFE);
    vec[12] = mk("bad_fnc",     1, 5'b00000, 32'h10, 32'h0, 1, 1, 0, 0, 32'h0);
    vec[13] = mk("lw_rw0",      0, 5'b01000, 32'h10, 32'h0, 1, 1, 0, 0, 32'h0);
    vec[14] = mk("sw_rw1",      1, 5'b01101, 32'h10, 32'h0, 1, 1, 0, 0, 32'h0);
    vec[15] = mk("lw_kept",     1, 5'b01000, 32'h10, 32'h0, 1, 1, 0, 0, 32'h11ABCAFE);
    vec[16] = mk("lw_mis",      1, 5'b01000, 32'h12, 32'h0, 1, 1, 1, 32'h11223344,
                 32'h11223344);
    vec[17] = mk("lw_wrap",     1, 5'b01000, 32'h1010, 32'h0, 1, 1, 1, 32'h5A5A5A5A,
                 32'h5A5A5A5A);
`ifdef MEM_ALIGN_TRAP_EN
    vec[16].exp = 32'h0;
`endif

    // Reset state
    reset = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_fnc = '0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset ram_en", 32'(ram_en), 32'd0);
    chk("reset ram_we", 32'(ram_we), 32'd0);
    chk("reset ram_addr", 32'(ram_addr), 32'd0);
    chk("reset ram_wdata", ram_wdata, 32'h0);
`ifdef MEM_ALIGN_TRAP_EN
    chk("reset misalign_err", 32'(misalign_err), 32'd0);
`endif
    reset = 1'b1;

    // Directed vectors
    for (int i = 0; i < 18; i++) begin
      if (vec[i].pre_en) begin
        ram_mem[vec[i].addr[11:2]] = vec[i].pre_val;
        mem_ref[vec[i].addr[11:2]] = vec[i].pre_val;
      end
      run_op(vec[i].name, vec[i].rw, vec[i].fnc, vec[i].addr, vec[i].wdata,
             vec[i].drd, vec[i].dwr, vec[i].exp);
    end
    chk("sw_deadbeef image", ram_mem[4] == 32'h5A5A5A5A ? 32'h1 : 32'h0, 32'h1);

    // Reset while the RMW write is pending: no write, no response
    ram_mem[6] = 32'h01020304; mem_ref[6] = 32'h01020304;
    dly_rd = 1; dly_wr = 20;
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b0; req_fnc = 5'b01111; req_addr = 32'h18;
    req_wdata = 32'hEE;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (ram_en && ram_we) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("abort reached_wr", 32'(seen), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort ram_en", 32'(ram_en), 32'd0);
    chk("abort req_ready", 32'(req_ready), 32'd1);
    chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid || ram_en) seen = 1;
    end
    chk("abort quiet", 32'(seen), 32'd0);
    chk("abort no_write", ram_mem[6], 32'h01020304);

    // Random aligned traffic against the reference model
    codes[0] = 5'b01000; codes[1] = 5'b01001; codes[2] = 5'b01010; codes[3] = 5'b01011;
    codes[4] = 5'b01100; codes[5] = 5'b01101; codes[6] = 5'b01110; codes[7] = 5'b01111;
    for (int n = 0; n < 150; n++) begin
      f  = codes[$urandom_range(0, 7)];
      sz = size_of(f);
      a  = 32'($urandom_range(0, 63));
      if (sz == 4) a = a & 32'hffff_fffc;
      if (sz == 2) a = a & 32'hffff_fffe;
      e  = (kind_of(f) == 1) ? ref_load(f, a) : 32'h0;
      run_op($sformatf("rnd%0d", n), kind_of(f) == 1, f, a, $urandom,
             $urandom_range(1, 3), $urandom_range(1, 3), e);
    end
    for (int i = 0; i < 16; i++) chk($sformatf("ram word %0d", i), ram_mem[i], mem_ref[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
